// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
// FSM encoding and the nop word also used by the instruction register.
package inst_fetch_queue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } ifq_state_e;

    // Widest supported word; users slice the low WORD_SIZE bits.
    localparam int NOP_MAX_W = 64;
    localparam logic [NOP_MAX_W-1:0] NOP_INST = '1;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Small circular buffer holding fetched {instruction, pc} pairs.
// Clear wins over push and pop in the same cycle.
module inst_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_push,
    input  logic [DW-1:0]               i_data,
    input  logic                        i_pop,
    input  logic                        i_clear,
    output logic [DW-1:0]               o_head,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: sequential memory reads into a small queue,
// feeding the instruction register with write/nop control each cycle.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int                   WORD_SIZE = 16,
    parameter int                   DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0] PC_RESET  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 mem_read,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 mem_ack,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] flush_pc,
    output logic                 ir_write,
    output logic [WORD_SIZE-1:0] ir_data,
    output logic                 ir_nop,
    output logic [WORD_SIZE-1:0] ir_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [WORD_SIZE-1:0] L_NOP = NOP_INST[WORD_SIZE-1:0];

    ifq_state_e             r_state;
    ifq_state_e             w_state_nxt;
    logic [WORD_SIZE-1:0]   r_fetch_pc;
    logic [WORD_SIZE-1:0]   w_fetch_pc_nxt;
    logic [WORD_SIZE-1:0]   r_drain_addr;
    logic [WORD_SIZE-1:0]   w_drain_addr_nxt;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [CW-1:0]          w_count;
    logic [CW:0]            w_count_ack;
    logic [2*WORD_SIZE-1:0] w_head;

    // Head leaves the queue only when decode takes it and no flush is active.
    assign w_pop = !flush && !stall && !w_empty;

    // Occupancy after an ack lands together with this cycle's pop.
    assign w_count_ack = {1'b0, w_count} + (CW+1)'(1) - (CW+1)'(w_pop);

    // Next-state, next fetch address and push decision.
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_drain_addr_nxt = r_drain_addr;
        w_push           = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (flush) begin
                    w_fetch_pc_nxt = flush_pc;
                    w_state_nxt    = FETCH;
                end else if (!w_full) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (flush) begin
                    w_fetch_pc_nxt = flush_pc;
                    if (mem_ack) begin
                        w_state_nxt = FETCH;
                    end else begin
                        w_state_nxt      = DRAIN;
                        w_drain_addr_nxt = r_fetch_pc;
                    end
                end else if (mem_ack) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 1'b1;
                    if (w_count_ack < (CW+1)'(DEPTH)) begin
                        w_state_nxt = FETCH;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (flush) begin
                    w_fetch_pc_nxt = flush_pc;
                end
                if (mem_ack) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and address registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_fetch_pc   <= PC_RESET;
            r_drain_addr <= PC_RESET;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_drain_addr <= w_drain_addr_nxt;
        end
    end

    inst_fifo #(
        .DW    (2*WORD_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  ({mem_data, r_fetch_pc}),
        .i_pop   (w_pop),
        .i_clear (flush),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign mem_read = (r_state != IDLE);
    assign mem_addr = (r_state == DRAIN) ? r_drain_addr : r_fetch_pc;

    assign ir_write = w_pop;
    assign ir_nop   = flush || (!stall && w_empty);
    assign ir_data  = w_empty ? L_NOP : w_head[2*WORD_SIZE-1:WORD_SIZE];
    assign ir_pc    = w_empty ? '0 : w_head[WORD_SIZE-1:0];

endmodule
